// File: rtl/multicycle_sequencer.sv
// Eight-phase control sequencer for the shared-port 8-bit accumulator CPU.
// Strobes decode the registered phase and latched opcode; HLT parks until run.
module multicycle_sequencer #(
    parameter int PHASES = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             run,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             ld_ac,
    output logic             wr,
    output logic             data_e,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_ADDR    = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD    = 4'd2,
        S_IDLE    = 4'd3,
        S_OPADDR  = 4'd4,
        S_OPFETCH = 4'd5,
        S_ALU     = 4'd6,
        S_STORE   = 4'd7,
        S_HALT    = 4'd8
    } state_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_ADDR:    state_d = S_FETCH;
            S_FETCH:   state_d = S_LOAD;
            S_LOAD:    state_d = S_IDLE;
            S_IDLE: begin
                state_d = S_OPADDR;
                op_d    = opcode;
            end
            S_OPADDR:  state_d = (op_q == OP_HLT) ? S_HALT : S_OPFETCH;
            S_OPFETCH: state_d = S_ALU;
            S_ALU:     state_d = S_STORE;
            S_STORE: begin
                state_d = S_ADDR;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HALT:    state_d = run ? S_ADDR : S_HALT;
            default:   state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ADDR;
            op_q    <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    logic       is_alu, is_skz, is_sto, is_jmp;
    logic       sel_c, rd_c, ld_ir_c, inc_pc_c, ld_pc_c;
    logic       ld_ac_c, wr_c, data_e_c, halted_c;
    logic [1:0] alu_dec, alu_op_c;

    assign is_alu = (op_q == OP_ADD) || (op_q == OP_AND) ||
                    (op_q == OP_XOR) || (op_q == OP_LDA);
    assign is_skz = (op_q == OP_SKZ);
    assign is_sto = (op_q == OP_STO);
    assign is_jmp = (op_q == OP_JMP);

    always_comb begin
        unique case (op_q)
            OP_ADD:  alu_dec = 2'b00;
            OP_AND:  alu_dec = 2'b01;
            OP_XOR:  alu_dec = 2'b10;
            OP_LDA:  alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    end

    always_comb begin
        sel_c    = 1'b0;
        rd_c     = 1'b0;
        ld_ir_c  = 1'b0;
        inc_pc_c = 1'b0;
        ld_pc_c  = 1'b0;
        ld_ac_c  = 1'b0;
        wr_c     = 1'b0;
        data_e_c = 1'b0;
        alu_op_c = 2'b00;
        halted_c = 1'b0;
        unique case (state_q)
            S_ADDR:  sel_c = 1'b1;
            S_FETCH: begin
                sel_c = 1'b1;
                rd_c  = 1'b1;
            end
            S_LOAD, S_IDLE: begin
                sel_c   = 1'b1;
                rd_c    = 1'b1;
                ld_ir_c = 1'b1;
            end
            S_OPADDR: inc_pc_c = 1'b1;
            S_OPFETCH: begin
                rd_c     = is_alu;
                alu_op_c = alu_dec;
            end
            S_ALU: begin
                rd_c     = is_alu;
                inc_pc_c = is_skz & zero;
                ld_pc_c  = is_jmp;
                data_e_c = is_sto;
                alu_op_c = alu_dec;
            end
            S_STORE: begin
                rd_c     = is_alu;
                ld_ac_c  = is_alu;
                ld_pc_c  = is_jmp;
                wr_c     = is_sto;
                data_e_c = is_sto;
                alu_op_c = alu_dec;
            end
            S_HALT:  halted_c = 1'b1;
            default: halted_c = 1'b0;
        endcase
    end

    // Everything reads as idle while reset is held, whatever the state.
    assign sel       = sel_c & rst;
    assign rd        = rd_c & rst;
    assign ld_ir     = ld_ir_c & rst;
    assign inc_pc    = inc_pc_c & rst;
    assign ld_pc     = ld_pc_c & rst;
    assign ld_ac     = ld_ac_c & rst;
    assign wr        = wr_c & rst;
    assign data_e    = data_e_c & rst;
    assign alu_op    = alu_op_c & {2{rst}};
    assign halted    = halted_c & rst;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-phase strobe vectors,
// halt/resume, mid-instruction reset and retired-counter wrap.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       run;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halted;
    logic [1:0] alu_op;
    logic [7:0] instr_cnt;

    int total = 0;
    int bad   = 0;

    multicycle_sequencer #(.PHASES(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .run       (run),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .data_e    (data_e),
        .alu_op    (alu_op),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,alu_op,halted}
    function automatic logic [10:0] outs();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac,
                wr, data_e, alu_op, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] F0 = 11'b1000000_0_00_0;
    localparam logic [10:0] F1 = 11'b1100000_0_00_0;
    localparam logic [10:0] F2 = 11'b1110000_0_00_0;
    localparam logic [10:0] P4 = 11'b0001000_0_00_0;
    localparam logic [10:0] NZ = 11'b0000000_0_00_0;
    localparam logic [10:0] HL = 11'b0000000_0_00_1;

    // Phase 0 vector occupies the top 11 bits; zero toggles outside phase 6.
    task automatic exec(input string tag, input logic [2:0] op,
                        input logic z, input int nph,
                        input logic [87:0] e);
        opcode = op;
        for (int p = 0; p < nph; p++) begin
            zero = (p == 6) ? z : ~z;
            #1;
            chk($sformatf("%s.p%0d", tag, p), 32'(outs()),
                32'(e[(7-p)*11 +: 11]));
            tick();
        end
        zero = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        run    = 1'b0;
        tick();
        tick();
        chk("rst_outs", 32'(outs()), 32'(NZ));
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b1;

        exec("lda", 3'd5, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_11_0, 11'b0100000_0_11_0,
             11'b0100010_0_11_0});
        chk("lda_cnt", 32'(instr_cnt), 32'd1);

        exec("sto", 3'd6, 1'b0, 8, {F0, F1, F2, F2, P4, NZ,
             11'b0000000_1_00_0, 11'b0000001_1_00_0});
        chk("sto_cnt", 32'(instr_cnt), 32'd2);

        exec("skz1", 3'd1, 1'b1, 8, {F0, F1, F2, F2, P4, NZ, P4, NZ});
        exec("skz0", 3'd1, 1'b0, 8, {F0, F1, F2, F2, P4, NZ, NZ, NZ});
        chk("skz_cnt", 32'(instr_cnt), 32'd4);

        exec("jmp", 3'd7, 1'b0, 8, {F0, F1, F2, F2, P4, NZ,
             11'b0000100_0_00_0, 11'b0000100_0_00_0});
        chk("jmp_cnt", 32'(instr_cnt), 32'd5);

        exec("add", 3'd2, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_00_0, 11'b0100000_0_00_0,
             11'b0100010_0_00_0});
        exec("and", 3'd3, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_01_0, 11'b0100000_0_01_0,
             11'b0100010_0_01_0});
        exec("xor", 3'd4, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_10_0, 11'b0100000_0_10_0,
             11'b0100010_0_10_0});
        chk("alu_cnt", 32'(instr_cnt), 32'd8);

        exec("hlt", 3'd0, 1'b0, 5, {F0, F1, F2, F2, P4, NZ, NZ, NZ});
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt%0d", i), 32'(outs()), 32'(HL));
            tick();
        end
        chk("hlt_cnt", 32'(instr_cnt), 32'd8);
        run = 1'b1;
        #1;
        chk("run_pre", 32'(outs()), 32'(HL));
        tick();
        run = 1'b0;
        chk("run_resume", 32'(outs()), 32'(F0));

        run = 1'b1;
        exec("hlt_run", 3'd0, 1'b0, 5, {F0, F1, F2, F2, P4, NZ, NZ, NZ});
        chk("hold_halt", 32'(outs()), 32'(HL));
        tick();
        chk("hold_resume", 32'(outs()), 32'(F0));
        exec("lda_run", 3'd5, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_11_0, 11'b0100000_0_11_0,
             11'b0100010_0_11_0});
        run = 1'b0;
        chk("run_ign_cnt", 32'(instr_cnt), 32'd9);

        exec("add_mid", 3'd2, 1'b0, 5, {F0, F1, F2, F2, P4, NZ, NZ, NZ});
        rst = 1'b0;
        #1;
        chk("mid_gate", 32'(outs()), 32'(NZ));
        tick();
        chk("mid_outs", 32'(outs()), 32'(NZ));
        chk("mid_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_fetch", 32'(outs()), 32'(F0));
        exec("post_rst", 3'd5, 1'b0, 8, {F0, F1, F2, F2, P4,
             11'b0100000_0_11_0, 11'b0100000_0_11_0,
             11'b0100010_0_11_0});
        chk("post_cnt", 32'(instr_cnt), 32'd1);

        opcode = 3'd5;
        for (int i = 0; i < 254; i++) repeat (8) tick();
        chk("cnt_255", 32'(instr_cnt), 32'd255);
        repeat (8) tick();
        chk("cnt_wrap", 32'(instr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- 8-phase multi-cycle control FSM for the 8-bit accumulator CPU (3-bit opcode, 5-bit operand address, 5-bit PC, ACC, ALU, single-ported memory).
- Replaces the single-cycle controller when IM and DM share one memory port and instructions take eight clocks.
- Drives PC, IR, ACC, ALU and memory strobes. Provides halt/resume and a retired-instruction counter.

Parameters:
- PHASES, 8, phases per instruction; fixed at 8, other values unsupported.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- opcode  in  3  IR[7:5]; valid from phase 3 onward.
- zero  in  1  ACC == 0; sampled in phase 6.
- run  in  1  resume pulse; only meaningful while halted.
- sel  out  1  1 = memory address from PC, 0 = from IR[4:0].
- rd  out  1  memory read enable.
- ld_ir  out  1  load IR from memory data.
- inc_pc  out  1  PC <= PC+1 (5-bit, wraps 31->0).
- ld_pc  out  1  PC <= IR[4:0].
- ld_ac  out  1  ACC <= ALU result.
- wr  out  1  memory write strobe.
- data_e  out  1  enable ACC onto memory data bus.
- alu_op  out  2  00 ADD, 01 AND, 10 XOR, 11 PASS (memory operand to ALU output).
- halted  out  1  FSM is in HALTED state.
- instr_cnt  out  CNT_W  number of instructions completed, wraps.

Behaviour:
- Opcode map: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. ALUOP = ADD|AND|XOR|LDA.
- State: 3-bit phase counter plus a HALTED state; op_q (3 bits) latched from opcode at the end of phase 3.
- All strobes are a combinational decode of the registered state and op_q. Strobes not listed for a phase are 0.
- Phase 0 INST_ADDR: sel.
- Phase 1 INST_FETCH: sel, rd.
- Phase 2 INST_LOAD: sel, rd, ld_ir.
- Phase 3 IDLE: sel, rd, ld_ir. Capture op_q at the end of this phase.
- Phase 4 OP_ADDR: inc_pc. If op_q == HLT, next state is HALTED; otherwise phase 5.
- Phase 5 OP_FETCH: rd = ALUOP.
- Phase 6 ALU_OP: rd = ALUOP; inc_pc = (SKZ & zero); ld_pc = JMP; data_e = STO.
- Phase 7 STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO. instr_cnt increments at the end of this phase; next state is phase 0.
- alu_op = decode(op_q) in phases 5-7. It is 00 in all other phases and in HALTED.
- Phase sequence 0->7 is strictly incremental and wraps 7->0. There is no early exit except HLT.
- HALTED:
  - All strobes are 0; halted = 1.
  - PC was already incremented in phase 4.
  - run = 1 at a clock edge moves to phase 0. halted drops the following cycle and execution resumes at the next instruction.
- run outside HALTED is ignored. A run held high across HLT resumes after exactly one HALTED cycle.
- zero is sampled only in phase 6. Changes in other phases have no effect.
- SKZ with zero = 1: PC advances twice (phases 4 and 6), skipping one instruction. Wrap follows 5-bit PC arithmetic.
- JMP: ld_pc overrides the phase 4 increment, because the load happens later.
- Reset:
  - rst = 0 at a clock edge forces phase 0, op_q = 0, instr_cnt = 0 and not halted. This applies from any state, including mid-instruction and HALTED.
  - While rst = 0, all strobes and alu_op read as 0 (decoded from phase 0 but gated) and halted = 0.
  - The first fetch (sel = 1) is in the first cycle after rst returns high.
- HLT does not increment instr_cnt. All other opcodes increment it once.

Test Plan:
- Reset then LDA 0x05 (IR = 0xA5): phases 0-7 in eight clocks; sel for phases 0-3; ld_ir in phases 2-3; inc_pc in phase 4; alu_op = 11 and rd in phases 5-7; ld_ac in phase 7; instr_cnt = 1.
- STO 0x1F (0xDF): data_e in phases 6-7, wr only in phase 7, rd = 0 in phases 5-7, ld_ac never asserted.
- SKZ (0x20), once with zero = 1 and once with zero = 0 in phase 6: inc_pc pulses in phases 4 and 6 vs phase 4 only. Toggling zero in phase 5 has no effect.
- JMP 0x10 (0xF0): ld_pc in phases 6-7, alu_op = 00, instr_cnt increments.
- HLT (0x00): inc_pc in phase 4, then halted = 1 with all strobes 0 for 20 cycles. A run pulse returns to phase 0 with halted = 0; instr_cnt is unchanged by the HLT.
- rst = 0 in phase 5 of ADD: the next cycle is phase 0 with all outputs 0 and instr_cnt = 0. Feeding 255 non-HLT instructions plus 1 more gives instr_cnt = 0 (wrap).
